uram_win_read: RTL and testbench
================================

URAM_WIN_READ -- requirements
Module: uram_win_read

Interface
- REQ-001 SHALL have parameter WIDTH, default 3072: URAM/FIFO data width in bits.
- REQ-002 SHALL have parameter URAM_ADDR, default 12: URAM address width.
- REQ-003 SHALL have parameter EXP_W, default 3072: exponent width; SHALL be a multiple of WIN.
- REQ-004 SHALL have parameter WIN, default 4: window width in bits, 1..8; NWIN = EXP_W/WIN.
- REQ-005 SHALL have parameter BASE_ADDR, default 0: URAM address of table entry 0.
- REQ-006 SHALL have port clk, input, 1: single clock, all logic rising-edge.
- REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
- REQ-008 SHALL have ports start, input, 1 (one-cycle request pulse) and e, input, EXP_W (exponent).
- REQ-009 SHALL have ports reg_e, output, EXP_W (latched exponent) and busy, output, 1.
- REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-011 SHALL have port wfull, input, 1: FIFO almost-full, asserted with at least 2 free slots remaining.
- REQ-012 SHALL have ports data_fifo, output, WIDTH; win_fifo, output, WIN; last_fifo, output, 1; write_fifo, output, 1.
- REQ-013 SHALL have ports data_uram, input, WIDTH; rd_uram, output, 1; rd_addr, output, URAM_ADDR.

Function
- REQ-014 SHALL implement FSM IDLE, SCAN, DRAIN, DONE.
- REQ-015 IDLE: start=1 SHALL latch e into reg_e, set window index to NWIN-1, and enter SCAN next cycle; busy=1 in all states except IDLE.
- REQ-016 start while busy=1 SHALL be ignored, with reg_e unchanged.
- REQ-017 SCAN, wfull=0: SHALL assert rd_uram for one cycle with rd_addr = (BASE_ADDR + reg_e[idx*WIN +: WIN]) mod 2^URAM_ADDR, then decrement idx.
- REQ-018 SCAN, wfull=1: SHALL hold rd_uram=0, with idx and rd_addr unchanged.
- REQ-019 Issuing the read at idx=0 SHALL move the FSM to DRAIN.
- REQ-020 Windows SHALL be issued MSB-first; a zero-valued window SHALL still be read (entry BASE_ADDR).
- REQ-021 write_fifo SHALL assert exactly LAT cycles after each rd_uram, where LAT is 1 by default and 2 under REQ-029.
  - data_fifo SHALL equal data_uram as sampled LAT-1 cycles after the read.
  - win_fifo SHALL equal the issuing window value.
  - last_fifo=1 only with the idx=0 window.
- REQ-022 Once issued, a read's write_fifo SHALL NOT be suppressed by wfull; REQ-011 margin covers in-flight data.
- REQ-023 DRAIN SHALL wait until the in-flight count is 0, then go to DONE; DONE SHALL pulse done=1 for one cycle and return to IDLE.
- REQ-024 write_fifo count per request SHALL equal NWIN exactly, with no duplicates or drops under any wfull pattern.

Reset
- REQ-025 rst=1 SHALL force, asynchronously, FSM=IDLE, reg_e=0, idx=0, busy=0, done=0, rd_uram=0, rd_addr=0, write_fifo=0, last_fifo=0, data_fifo=0, win_fifo=0, and clear the in-flight pipeline.
- REQ-026 Reset mid-request SHALL discard all in-flight reads; no write_fifo SHALL appear after deassertion until a new start.
- REQ-027 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
- REQ-028 Macro URAM_OREG_EN SHALL select the data-path latency.
- REQ-029 With URAM_OREG_EN defined: data_uram SHALL be registered internally; LAT=2; wfull margin requirement SHALL be 3 slots.
- REQ-030 Without URAM_OREG_EN: data_uram SHALL be captured directly; LAT=1; margin 2 slots; no extra register stage.

Verification
- REQ-031 EXP_W=8, WIN=4, BASE_ADDR=0, e=8'hA5, wfull=0: rd_addr 0xA then 0x5 on consecutive cycles; two write_fifo, win_fifo 0xA then 0x5, last_fifo on second; done one cycle after drain.
- REQ-032 Same setup, wfull=1 for 3 cycles after entering SCAN: no rd_uram during those cycles; reads resume on wfull=0; exactly 2 writes.
- REQ-033 BASE_ADDR=4094, URAM_ADDR=12, window value 3: rd_addr=1 (wrap).
- REQ-034 Second start 1 cycle after the first: ignored; reg_e keeps the first e; exactly NWIN writes and one done.
- REQ-035 rst=1 asserted with one read in flight: write_fifo never asserts afterward; all outputs 0; busy=0.
- REQ-036 Run REQ-031 with and without URAM_OREG_EN: write_fifo at rd_uram+2 and rd_uram+1 respectively.

Source files
------------

// File: rtl/uram_win_read.sv
// uram_win_read: walks the exponent e window by window (MSB first). Each
// window selects one URAM table entry. Each returned word is pushed into a
// downstream FIFO together with its window value and a last flag.
// Build option: define URAM_OREG_EN to register data_uram internally. This
// gives two cycles of read-to-write latency instead of one, and the wfull
// margin must then cover three in-flight words instead of two.
module uram_win_read #(
    parameter int WIDTH     = 3072,
    parameter int URAM_ADDR = 12,
    parameter int EXP_W     = 3072,
    parameter int WIN       = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W-1:0]     e,
    output logic [EXP_W-1:0]     reg_e,
    output logic                 busy,
    output logic                 done,
    input  logic                 wfull,
    output logic [WIDTH-1:0]     data_fifo,
    output logic [WIN-1:0]       win_fifo,
    output logic                 last_fifo,
    output logic                 write_fifo,
    input  logic [WIDTH-1:0]     data_uram,
    output logic                 rd_uram,
    output logic [URAM_ADDR-1:0] rd_addr
);
    localparam int NWIN  = EXP_W / WIN;
    localparam int IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NWIN - 1);

    // state | meaning
    // IDLE  | waiting for start, not busy
    // SCAN  | issuing one URAM read per window while FIFO has room
    // DRAIN | all reads issued, waiting for in-flight words to land
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [WIN-1:0]   cur_win;
    logic [WIN-1:0]   win_q;
    logic             last_q;
    logic             accept;
    logic             issue;
    logic             pipe_busy;

    assign cur_win = reg_e[idx*WIN +: WIN];

`ifdef URAM_OREG_EN
    logic           v1;
    logic [WIN-1:0] w1;
    logic           l1;
    assign pipe_busy = rd_uram | v1;
`else
    assign pipe_busy = rd_uram;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!wfull) begin
                    issue = 1'b1;
                    if (idx == '0) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Exponent latch, window index and URAM read issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_e   <= '0;
            idx     <= '0;
            rd_uram <= 1'b0;
            rd_addr <= '0;
            win_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            rd_uram <= issue;
            if (accept) begin
                reg_e <= e;
                idx   <= IDX_TOP;
            end
            if (issue) begin
                rd_addr <= URAM_ADDR'(BASE_ADDR + int'(cur_win));
                win_q   <= cur_win;
                last_q  <= (idx == '0);
                if (idx != '0) idx <= idx - IDX_W'(1);
            end
        end
    end

`ifdef URAM_OREG_EN
    // Two-stage return path: read tag delayed one cycle, data_uram captured a cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1         <= 1'b0;
            w1         <= '0;
            l1         <= 1'b0;
            write_fifo <= 1'b0;
            last_fifo  <= 1'b0;
            data_fifo  <= '0;
            win_fifo   <= '0;
        end else begin
            v1         <= rd_uram;
            write_fifo <= v1;
            last_fifo  <= v1 & l1;
            if (rd_uram) begin
                w1 <= win_q;
                l1 <= last_q;
            end
            if (v1) begin
                data_fifo <= data_uram;
                win_fifo  <= w1;
            end
        end
    end
`else
    // Single-stage return path: data_uram captured straight into the FIFO word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_fifo <= 1'b0;
            last_fifo  <= 1'b0;
            data_fifo  <= '0;
            win_fifo   <= '0;
        end else begin
            write_fifo <= rd_uram;
            last_fifo  <= rd_uram & last_q;
            if (rd_uram) begin
                data_fifo <= data_uram;
                win_fifo  <= win_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uram_win_read.sv
// Bench for uram_win_read: directed and randomized requests checked against
// a list-of-windows reference model and a queue of outstanding reads.
module tb_uram_win_read;
    localparam int WIDTH     = 16;
    localparam int URAM_ADDR = 12;
    localparam int EXP_W     = 16;
    localparam int WIN       = 4;
    localparam int BASE_ADDR = 4094;
    localparam int NWIN      = EXP_W / WIN;
`ifdef URAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [EXP_W-1:0]     e = '0;
    logic [EXP_W-1:0]     reg_e;
    logic                 busy;
    logic                 done;
    logic                 wfull = 1'b0;
    logic [WIDTH-1:0]     data_fifo;
    logic [WIN-1:0]       win_fifo;
    logic                 last_fifo;
    logic                 write_fifo;
    logic [WIDTH-1:0]     data_uram = '0;
    logic                 rd_uram;
    logic [URAM_ADDR-1:0] rd_addr;

    uram_win_read #(
        .WIDTH(WIDTH), .URAM_ADDR(URAM_ADDR), .EXP_W(EXP_W),
        .WIN(WIN), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .e(e), .reg_e(reg_e),
        .busy(busy), .done(done), .wfull(wfull), .data_fifo(data_fifo),
        .win_fifo(win_fifo), .last_fifo(last_fifo), .write_fifo(write_fifo),
        .data_uram(data_uram), .rd_uram(rd_uram), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int win; bit last; } rd_exp_t;
    typedef struct { int cyc;  int win; bit last; } fl_t;

    rd_exp_t          exp_q[$];
    fl_t              fl_q[$];
    int               rd_cycs[$];
    logic [WIDTH-1:0] data_hist [int];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  last_wr_cyc = 0;
    int  done_cyc = 0;
    bit  wfull_edge = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and the wfull value each edge actually saw
    always @(posedge clk) begin
        cyc        = cyc + 1;
        wfull_edge = wfull;
    end

    // Monitor: match reads to the model, writes to outstanding reads; drive URAM data
    always @(negedge clk) begin : mon
        rd_exp_t r;
        fl_t     f;
        if (!rst) begin
            if (rd_uram) begin
                chk("rd_while_wfull", wfull_edge, 1'b0);
                rd_cycs.push_back(cyc);
                if (exp_q.size() == 0) chk("rd_extra", rd_uram, 1'b0);
                else begin
                    r = exp_q.pop_front();
                    chk("rd_addr", rd_addr, r.addr);
                    fl_q.push_back(fl_t'{cyc, r.win, r.last});
                end
            end
            if (write_fifo) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (fl_q.size() == 0) chk("wr_extra", write_fifo, 1'b0);
                else begin
                    f = fl_q.pop_front();
                    chk("wr_latency", cyc - f.cyc, LAT);
                    chk("win_fifo", win_fifo, f.win);
                    chk("last_fifo", last_fifo, f.last);
                    chk("data_fifo", data_fifo, data_hist[f.cyc + LAT - 1]);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        data_uram = WIDTH'($urandom);
        data_hist[cyc] = data_uram;
    end

    task automatic load_model(input logic [EXP_W-1:0] ev);
        for (int i = NWIN - 1; i >= 0; i--) begin
            int w;
            w = (int'(ev) >> (i * WIN)) & ((1 << WIN) - 1);
            exp_q.push_back(rd_exp_t'{(BASE_ADDR + w) % (1 << URAM_ADDR), w, i == 0});
        end
    endtask

    // wmode: 0 never full, 1 random full, 2 full for the first three SCAN edges
    task automatic run_req(input logic [EXP_W-1:0] ev, input int wmode,
                           input bit dup, input logic [EXP_W-1:0] ev2);
        int s_cyc;
        exp_q.delete();
        fl_q.delete();
        rd_cycs.delete();
        load_model(ev);
        wr_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        e     = ev;
        wfull = 1'b0;
        s_cyc = cyc;
        @(negedge clk);
        start = dup;
        e     = dup ? ev2 : EXP_W'($urandom);
        wfull = (wmode == 2) || (wmode == 1 && $urandom_range(1, 0) == 1);
        chk("busy_active", busy, 1'b1);
        chk("reg_e_latch", reg_e, ev);
        for (int n = 0; n < 200 && done_cnt == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            case (wmode)
                1:       wfull = ($urandom_range(2, 0) == 0);
                2:       wfull = (n < 2);
                default: wfull = 1'b0;
            endcase
        end
        wfull = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_cnt, NWIN);
        chk("reads_left", exp_q.size(), 0);
        chk("inflight_left", fl_q.size(), 0);
        chk("busy_after", busy, 1'b0);
        chk("reg_e_hold", reg_e, ev);
        chk("done_after_last_wr", done_cyc, last_wr_cyc + 1);
        if (wmode != 1 && rd_cycs.size() == NWIN) begin
            for (int i = 0; i < NWIN; i++)
                chk("rd_cycle", rd_cycs[i] - s_cyc, (wmode == 2 ? 5 : 2) + i);
        end
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_uram", rd_uram, 1'b0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_write_fifo", write_fifo, 1'b0);
        chk("rst_last_fifo", last_fifo, 1'b0);
        chk("rst_data_fifo", data_fifo, 0);
        chk("rst_win_fifo", win_fifo, 0);
        chk("rst_reg_e", reg_e, 0);
        rst = 1'b0;

        run_req(16'hA5A5, 0, 1'b0, '0);
        run_req(16'hA5A5, 2, 1'b0, '0);
        run_req(16'h3210, 0, 1'b0, '0);
        run_req(16'h0000, 1, 1'b0, '0);
        run_req(16'hFFFF, 0, 1'b1, 16'h1234);

        // Reset with a read in flight
        exp_q.delete();
        fl_q.delete();
        load_model(16'h5A3C);
        @(negedge clk);
        start = 1'b1;
        e     = 16'h5A3C;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10 && !rd_uram; n++) @(negedge clk);
        chk("rd_before_rst", rd_uram, 1'b1);
        #2 rst = 1'b1;
        exp_q.delete();
        fl_q.delete();
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_uram", rd_uram, 1'b0);
        chk("mid_rst_write_fifo", write_fifo, 1'b0);
        chk("mid_rst_last_fifo", last_fifo, 1'b0);
        chk("mid_rst_data_fifo", data_fifo, 0);
        chk("mid_rst_win_fifo", win_fifo, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_reg_e", reg_e, 0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        wr_cnt = 0;
        repeat (8) @(negedge clk);
        chk("wr_after_rst", wr_cnt, 0);
        chk("busy_after_rst", busy, 1'b0);

        for (int k = 0; k < 12; k++)
            run_req(EXP_W'($urandom), $urandom_range(1, 0), ($urandom_range(3, 0) == 0),
                    EXP_W'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
